// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared types and sizing helpers for the PLL reset sequencer
package pll_rst_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Counter only has to reach the larger of the two terminal values minus one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage flop synchronizer with synchronous clear
module sync_ff #(
    parameter int N = 2
) (
    input  logic clock,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    always_ff @(posedge clock) begin
        if (clear) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - turns async PLL lock into a clean, debounced system reset
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int CNT_W              = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               lock,
    input  logic               soft_rst_req,
    output logic               rst_out,
    output logic               lock_stable,
    output logic [CNT_W-1:0]   loss_count,
    output logic [STATE_W-1:0] state
);

    localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [CNT_W-1:0] loss_q, loss_n;
    logic             lock_s;

    sync_ff #(.N(SYNC_STAGES)) u_lock_sync (
        .clock (clock),
        .clear (reset),
        .d     (lock),
        .q     (lock_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            loss_q  <= loss_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        loss_n  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_n = '0;
                if (lock_s) state_n = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RUN: begin
                // Lock loss outranks a simultaneous soft request and is the only counted event.
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                    if (loss_q != '1) loss_n = loss_q + 1'b1;
                end else if (soft_rst_req) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        rst_out     = (state_q != RUN);
        lock_stable = (state_q == HOLD) || (state_q == RUN);
        loss_count  = loss_q;
        state       = state_q;
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       lock;
    logic       soft_rst_req;
    logic       rst_out;
    logic       lock_stable;
    logic [7:0] loss_count;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RST_HOLD_CYCLES    (4),
        .CNT_W              (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .lock         (lock),
        .soft_rst_req (soft_rst_req),
        .rst_out      (rst_out),
        .lock_stable  (lock_stable),
        .loss_count   (loss_count),
        .state        (state)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    // Lock already low for >= 2 edges: relocking gives STABLE at edge 3, RUN at edge 15.
    task automatic relock_to_run(input string tag);
        lock = 1'b1;
        tick(14);
        chk({tag, "_e14_state"}, state, 2);
        chk({tag, "_e14_rst"}, rst_out, 1);
        tick(1);
        chk({tag, "_e15_state"}, state, 3);
        chk({tag, "_e15_rst"}, rst_out, 0);
    endtask

    initial begin
        reset = 1'b1;
        lock = 1'b0;
        soft_rst_req = 1'b0;
        tick(1);
        chk("rst_state", state, 0);
        chk("rst_rst_out", rst_out, 1);
        chk("rst_lock_stable", lock_stable, 0);
        chk("rst_loss", loss_count, 0);

        // Power-up: lock high from before edge 1
        reset = 1'b0;
        lock = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            chk($sformatf("pu_state_e%0d", e), state,
                (e < 3) ? 0 : (e < 11) ? 1 : (e < 15) ? 2 : 3);
            chk($sformatf("pu_rst_e%0d", e), rst_out, (e < 15) ? 1 : 0);
            chk($sformatf("pu_ls_e%0d", e), lock_stable, (e >= 11) ? 1 : 0);
        end

        // One-cycle lock glitch during STABLE
        do_reset();
        lock = 1'b1;
        tick(6);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(1);
        chk("gl_e8_state", state, 1);
        tick(1);
        chk("gl_e9_state", state, 0);
        tick(1);
        chk("gl_e10_state", state, 1);
        tick(11);
        chk("gl_e21_state", state, 2);
        chk("gl_e21_rst", rst_out, 1);
        tick(1);
        chk("gl_e22_state", state, 3);
        chk("gl_e22_rst", rst_out, 0);
        chk("gl_loss", loss_count, 0);

        // Lock loss in RUN
        lock = 1'b0;
        tick(2);
        chk("ll_e2_rst", rst_out, 0);
        tick(1);
        chk("ll_e3_rst", rst_out, 1);
        chk("ll_e3_state", state, 0);
        chk("ll_loss", loss_count, 1);
        relock_to_run("ll_relock");

        // Soft reset in RUN, second pulse in HOLD ignored
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        chk("sr_e1_state", state, 2);
        chk("sr_e1_rst", rst_out, 1);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        chk("sr_e2_state", state, 2);
        tick(2);
        chk("sr_e4_rst", rst_out, 1);
        chk("sr_e4_ls", lock_stable, 1);
        tick(1);
        chk("sr_e5_state", state, 3);
        chk("sr_e5_rst", rst_out, 0);
        chk("sr_loss", loss_count, 1);

        // Lock loss and soft request reach the FSM together
        lock = 1'b0;
        tick(2);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        chk("both_state", state, 0);
        chk("both_loss", loss_count, 2);

        // 300 further loss events saturate the counter
        for (int i = 1; i <= 300; i++) begin
            lock = 1'b1;
            tick(15);
            lock = 1'b0;
            tick(3);
            if (i == 252) chk("sat_254", loss_count, 254);
            if (i == 253) chk("sat_255", loss_count, 255);
        end
        chk("sat_final", loss_count, 255);
        chk("sat_state", state, 0);

        // Reset mid-HOLD
        relock_to_run("pre_hold");
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        tick(1);
        chk("mh_in_hold", state, 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mh_state", state, 0);
        chk("mh_rst", rst_out, 1);
        chk("mh_ls", lock_stable, 0);
        chk("mh_loss", loss_count, 0);
        tick(2);
        chk("mh_e2_state", state, 0);
        tick(1);
        chk("mh_e3_state", state, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
